// File: rtl/accumulate_scheduler.sv
// Shares one floating-point accumulator between NUM_REQ vector requesters. Packets are granted
// one at a time in round-robin order, zero-padded to the tree width, and tagged with their owner.
module accumulate_scheduler #(
    parameter int unsigned FRAC_WIDTH      = 24,
    parameter int unsigned EXP_WIDTH       = 8,
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned PAD_LOG2        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned DATA_WIDTH     = FRAC_WIDTH + EXP_WIDTH,
    localparam int unsigned ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [NUM_REQ-1:0]            reqValidIn,
    input  logic [NUM_REQ-1:0]            reqLastIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
    output logic [NUM_REQ-1:0]            reqReadyOut,
    output logic                          accStartOut,
    output logic                          accLastOut,
    output logic                          accValidOut,
    output logic [DATA_WIDTH-1:0]         accDataOut,
    input  logic                          accValidIn,
    input  logic [DATA_WIDTH-1:0]         accDataIn,
    output logic                          resValidOut,
    output logic [ID_WIDTH-1:0]           resIdOut,
    output logic [DATA_WIDTH-1:0]         resDataOut,
    output logic                          errOut
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {Idle, Stream, Pad} stateT;

    stateT                 state;
    logic [ID_WIDTH-1:0]   owner;
    logic [ID_WIDTH-1:0]   rrPtr;
    logic [ID_WIDTH-1:0]   winner;
    logic                  anyValid;
    logic [PAD_LOG2-1:0]   beatCnt;
    logic                  firstBeat;
    logic [ID_WIDTH-1:0]   tagMem [MAX_OUTSTANDING];
    logic [PTR_WIDTH-1:0]  wrPtr;
    logic [PTR_WIDTH-1:0]  rdPtr;
    logic [CNT_WIDTH-1:0]  outCount;
    logic [DATA_WIDTH-1:0] ownerData;
    logic                  ownerValid;
    logic                  ownerLast;
    logic                  grant;
    logic                  pop;
    logic                  xfer;

    // Descending scan so the requester nearest after the last winner overwrites farther ones.
    always_comb begin
        winner   = rrPtr;
        anyValid = 1'b0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            int idx;
            idx = (int'(rrPtr) + i) % int'(NUM_REQ);
            if (reqValidIn[idx]) begin
                winner   = ID_WIDTH'(idx);
                anyValid = 1'b1;
            end
        end
    end

    always_comb begin
        ownerData = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (ID_WIDTH'(r) == owner) ownerData = reqDataIn[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign ownerValid = reqValidIn[owner];
    assign ownerLast  = reqLastIn[owner];
    // Full check uses the registered count, so a same-cycle pop cannot unblock a grant.
    assign grant      = (state == Idle) && anyValid && (outCount < MAX_CNT);
    assign pop        = accValidIn && (outCount != '0);
    assign xfer       = (state == Stream) && ownerValid;

    always_comb begin
        reqReadyOut = '0;
        if (state == Stream) reqReadyOut[owner] = 1'b1;
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state       <= Idle;
            owner       <= '0;
            rrPtr       <= ID_WIDTH'(NUM_REQ - 1);
            beatCnt     <= '0;
            firstBeat   <= 1'b0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            outCount    <= '0;
            accStartOut <= 1'b0;
            accLastOut  <= 1'b0;
            accValidOut <= 1'b0;
            accDataOut  <= '0;
            resValidOut <= 1'b0;
            resIdOut    <= '0;
            resDataOut  <= '0;
            errOut      <= 1'b0;
            for (int k = 0; k < int'(MAX_OUTSTANDING); k++) tagMem[k] <= '0;
        end else begin
            accStartOut <= 1'b0;
            accLastOut  <= 1'b0;
            accValidOut <= 1'b0;
            resValidOut <= pop;

            if (pop) begin
                resIdOut   <= tagMem[rdPtr];
                resDataOut <= accDataIn;
                rdPtr      <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
            end
            if (accValidIn && (outCount == '0)) errOut <= 1'b1;

            if (grant) begin
                tagMem[wrPtr] <= winner;
                wrPtr         <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
            end
            if (grant && !pop)      outCount <= outCount + 1'b1;
            else if (!grant && pop) outCount <= outCount - 1'b1;

            case (state)
                Idle: begin
                    if (grant) begin
                        owner     <= winner;
                        rrPtr     <= winner;
                        beatCnt   <= '0;
                        firstBeat <= 1'b1;
                        state     <= Stream;
                    end
                end
                Stream: begin
                    if (xfer) begin
                        accValidOut <= 1'b1;
                        accDataOut  <= ownerData;
                        accStartOut <= firstBeat;
                        firstBeat   <= 1'b0;
                        beatCnt     <= beatCnt + 1'b1;
                        if (ownerLast) begin
                            if (beatCnt == '1) begin
                                accLastOut <= 1'b1;
                                state      <= Idle;
                            end else begin
                                state <= Pad;
                            end
                        end
                    end
                end
                Pad: begin
                    accValidOut <= 1'b1;
                    accDataOut  <= '0;
                    beatCnt     <= beatCnt + 1'b1;
                    if (beatCnt == '1) begin
                        accLastOut <= 1'b1;
                        state      <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulate_scheduler.sv
// Directed bench for accumulate_scheduler; the bench itself plays the accumulator result side.
module tb_accumulate_scheduler;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic [1:0]  reqValidIn;
    logic [1:0]  reqLastIn;
    logic [63:0] reqDataIn;
    logic [1:0]  reqReadyOut;
    logic        accStartOut;
    logic        accLastOut;
    logic        accValidOut;
    logic [31:0] accDataOut;
    logic        accValidIn;
    logic [31:0] accDataIn;
    logic        resValidOut;
    logic [0:0]  resIdOut;
    logic [31:0] resDataOut;
    logic        errOut;

    int checks = 0;
    int errors = 0;

    always #5 clkIn = ~clkIn;

    accumulate_scheduler dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .reqValidIn  (reqValidIn),
        .reqLastIn   (reqLastIn),
        .reqDataIn   (reqDataIn),
        .reqReadyOut (reqReadyOut),
        .accStartOut (accStartOut),
        .accLastOut  (accLastOut),
        .accValidOut (accValidOut),
        .accDataOut  (accDataOut),
        .accValidIn  (accValidIn),
        .accDataIn   (accDataIn),
        .resValidOut (resValidOut),
        .resIdOut    (resIdOut),
        .resDataOut  (resDataOut),
        .errOut      (errOut)
    );

    typedef struct {
        int          id;
        int          len;
        logic [31:0] data;
        logic [31:0] sum;
        int          padded;
    } vecT;

    vecT vecs[4];
    int  grantQ[$];
    int  lenQ[$];
    int  badData;
    int  startErr;
    int  idleCycles;
    int  firstGrantIter;
    bit  timedOut;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Streams n packets of len beats per requester and watches the accumulator beat stream.
    task automatic runTraffic(input int len0, input int n0, input logic [31:0] d0,
                              input int len1, input int n1, input logic [31:0] d1);
        int          len[2];
        int          pk[2];
        int          bt[2];
        logic [31:0] d[2];
        bit          pend[2];
        logic [1:0]  prevReady;
        int          total;
        int          pktDone;
        int          accIdx;
        int          own;
        len = '{len0, len1};
        pk  = '{n0, n1};
        bt  = '{0, 0};
        d   = '{d0, d1};
        pend = '{1'b0, 1'b0};
        grantQ.delete();
        lenQ.delete();
        badData = 0;
        startErr = 0;
        idleCycles = 0;
        firstGrantIter = -1;
        timedOut = 1'b1;
        total = n0 + n1;
        pktDone = 0;
        accIdx = 0;
        prevReady = reqReadyOut;
        reqDataIn = {d1, d0};
        for (int r = 0; r < 2; r++) begin
            reqValidIn[r] = pk[r] > 0;
            reqLastIn[r]  = bt[r] == len[r] - 1;
        end
        for (int iter = 1; iter <= 3000; iter++) begin
            @(negedge clkIn);
            if (accValidOut) begin
                own = (pktDone < grantQ.size()) ? grantQ[pktDone] : 0;
                if (accStartOut !== (accIdx == 0)) startErr++;
                if (accDataOut !== ((accIdx < len[own]) ? d[own] : 32'h0)) badData++;
                accIdx++;
                if (accLastOut) begin
                    lenQ.push_back(accIdx);
                    accIdx = 0;
                    pktDone++;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (pend[r]) begin
                    bt[r]++;
                    if (bt[r] == len[r]) begin
                        bt[r] = 0;
                        pk[r]--;
                    end
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (reqReadyOut[r] && !prevReady[r]) begin
                    grantQ.push_back(r);
                    if (firstGrantIter < 0) firstGrantIter = iter;
                end
            end
            if (reqReadyOut == 2'b00 && grantQ.size() > 0 && pk[0] + pk[1] > 0) idleCycles++;
            prevReady = reqReadyOut;
            for (int r = 0; r < 2; r++) begin
                reqValidIn[r] = pk[r] > 0;
                reqLastIn[r]  = bt[r] == len[r] - 1;
                pend[r]       = reqValidIn[r] && reqReadyOut[r];
            end
            if (pk[0] + pk[1] == 0 && pktDone == total) begin
                timedOut = 1'b0;
                break;
            end
        end
        reqValidIn = 2'b00;
        reqLastIn  = 2'b00;
        check("traffic_timeout", 32'(timedOut), 32'd0);
    endtask

    task automatic giveResult(input logic [31:0] sum, input int expId, input string tag);
        @(negedge clkIn);
        accValidIn = 1'b1;
        accDataIn  = sum;
        @(negedge clkIn);
        accValidIn = 1'b0;
        check({tag, "_resvalid"}, 32'(resValidOut), 32'd1);
        check({tag, "_resid"}, 32'(resIdOut), 32'(expId));
        check({tag, "_resdata"}, resDataOut, sum);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ready"}, 32'(reqReadyOut), 32'd0);
        check({tag, "_accctl"}, 32'({accValidOut, accStartOut, accLastOut}), 32'd0);
        check({tag, "_accdata"}, accDataOut, 32'd0);
        check({tag, "_resctl"}, 32'({resValidOut, resIdOut, errOut}), 32'd0);
        check({tag, "_resdata"}, resDataOut, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int expGrant[4];
        int held;
        int n;
        rstIn      = 1'b0;
        reqValidIn = '0;
        reqLastIn  = '0;
        reqDataIn  = '0;
        accValidIn = 1'b0;
        accDataIn  = '0;

        vecs[0] = '{id: 0, len: 16, data: 32'h3F800000, sum: 32'h41800000, padded: 16};
        vecs[1] = '{id: 1, len: 5,  data: 32'h40000000, sum: 32'h41200000, padded: 16};
        vecs[2] = '{id: 0, len: 1,  data: 32'h3F800000, sum: 32'h3F800000, padded: 16};
        vecs[3] = '{id: 1, len: 17, data: 32'h3F800000, sum: 32'h41880000, padded: 32};

        repeat (2) @(negedge clkIn);
        checkAllZero("reset");
        rstIn = 1'b1;
        @(negedge clkIn);

        foreach (vecs[i]) begin
            if (vecs[i].id == 0) runTraffic(vecs[i].len, 1, vecs[i].data, 0, 0, 32'h0);
            else                 runTraffic(0, 0, 32'h0, vecs[i].len, 1, vecs[i].data);
            check($sformatf("v%0d_latency", i), 32'(firstGrantIter), 32'd1);
            check($sformatf("v%0d_grant", i), 32'((grantQ.size() == 1) ? grantQ[0] : 99),
                  32'(vecs[i].id));
            check($sformatf("v%0d_beats", i), 32'((lenQ.size() == 1) ? lenQ[0] : -1),
                  32'(vecs[i].padded));
            check($sformatf("v%0d_baddata", i), 32'(badData), 32'd0);
            check($sformatf("v%0d_starterr", i), 32'(startErr), 32'd0);
            giveResult(vecs[i].sum, vecs[i].id, $sformatf("v%0d", i));
        end

        // Both requesters continuously valid: strict alternation, one idle cycle per gap.
        runTraffic(16, 2, 32'h3F800000, 16, 2, 32'h40000000);
        expGrant = '{0, 1, 0, 1};
        check("rr_count", 32'(grantQ.size()), 32'd4);
        for (int k = 0; k < 4 && k < grantQ.size(); k++)
            check($sformatf("rr_grant%0d", k), 32'(grantQ[k]), 32'(expGrant[k]));
        check("rr_idle", 32'(idleCycles), 32'd3);
        check("rr_pkts", 32'(lenQ.size()), 32'd4);
        check("rr_baddata", 32'(badData), 32'd0);
        check("rr_starterr", 32'(startErr), 32'd0);
        giveResult(32'h41800000, 0, "rr0");
        giveResult(32'h42000000, 1, "rr1");
        giveResult(32'h41800000, 0, "rr2");
        giveResult(32'h42000000, 1, "rr3");

        // Fill the tag FIFO, then a further request must wait for a pop.
        runTraffic(0, 0, 32'h0, 16, 4, 32'h3F800000);
        check("full_grants", 32'(grantQ.size()), 32'd4);
        reqDataIn[31:0] = 32'h3F800000;
        reqValidIn = 2'b01;
        reqLastIn  = 2'b01;
        held = 0;
        repeat (6) begin
            @(negedge clkIn);
            if (reqReadyOut != 2'b00) held++;
        end
        check("full_hold", 32'(held), 32'd0);
        accValidIn = 1'b1;
        accDataIn  = 32'h41800000;
        @(negedge clkIn);
        accValidIn = 1'b0;
        check("pop_same_cycle_ready", 32'(reqReadyOut), 32'd0);
        check("pop_resvalid", 32'(resValidOut), 32'd1);
        check("pop_resid", 32'(resIdOut), 32'd1);
        @(negedge clkIn);
        check("regrant_ready", 32'(reqReadyOut), 32'd1);
        @(negedge clkIn);
        reqValidIn = 2'b00;
        reqLastIn  = 2'b00;
        repeat (20) @(negedge clkIn);
        giveResult(32'h41800000, 1, "full1");
        giveResult(32'h41800000, 1, "full2");
        giveResult(32'h41800000, 1, "full3");
        giveResult(32'h3F800000, 0, "full4");

        // Result with nothing outstanding.
        @(negedge clkIn);
        accValidIn = 1'b1;
        accDataIn  = 32'hDEADBEEF;
        @(negedge clkIn);
        accValidIn = 1'b0;
        check("orphan_err", 32'(errOut), 32'd1);
        check("orphan_resvalid", 32'(resValidOut), 32'd0);
        repeat (3) @(negedge clkIn);
        check("orphan_err_sticky", 32'(errOut), 32'd1);

        // Reset while the seventh beat of a packet is on the accumulator port.
        reqDataIn[31:0] = 32'h3F800000;
        reqValidIn = 2'b01;
        reqLastIn  = 2'b00;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clkIn);
            if (accValidOut) n++;
            if (n == 7) break;
        end
        check("midpkt_beats", 32'(n), 32'd7);
        #2 rstIn = 1'b0;
        #1 checkAllZero("midrst");
        reqValidIn = 2'b00;
        @(negedge clkIn);
        rstIn = 1'b1;
        @(negedge clkIn);
        runTraffic(16, 1, 32'h3F800000, 0, 0, 32'h0);
        check("postrst_grant", 32'((grantQ.size() == 1) ? grantQ[0] : 99), 32'd0);
        check("postrst_beats", 32'((lenQ.size() == 1) ? lenQ[0] : -1), 32'd16);
        check("postrst_baddata", 32'(badData), 32'd0);
        giveResult(32'h41800000, 0, "postrst");
        @(negedge clkIn);
        accValidIn = 1'b1;
        @(negedge clkIn);
        accValidIn = 1'b0;
        check("postrst_fifo_empty_err", 32'(errOut), 32'd1);
        check("postrst_fifo_empty_res", 32'(resValidOut), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
